pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer with priority redirect mux and optional return-address stack (macro PC_SEQUENCER_RAS_EN)
module pc_sequencer #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_3000,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            br_take,
   input  logic [15:0]     br_offset,
   input  logic            j_take,
   input  logic [25:0]     j_addr,
   input  logic            jr_take,
   input  logic [XLEN-1:0] jr_target,
   input  logic            call,
   input  logic            ret,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            redirect,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_empty,
   output logic            ras_full
);

   logic [XLEN-1:0] brTgt;
   logic [XLEN-1:0] jTgt;
   logic [XLEN-1:0] nextPc;
   logic            anyTake;
   logic            accept;

   assign pc_plus4 = pc + XLEN'(4);
   assign brTgt    = pc_plus4 + ({{(XLEN-16){br_offset[15]}}, br_offset} << 2);
   assign jTgt     = {pc_plus4[XLEN-1:28], j_addr, 2'b00};
   assign anyTake  = jr_take | j_take | br_take;
   // A redirect always wins over stall; otherwise stall freezes the whole sequencer.
   assign accept   = anyTake | ~stall;

   // Next-PC priority mux: register jump, region jump, branch, then fall-through.
   always_comb begin
      nextPc = pc_plus4;
      if (jr_take)
         nextPc = jr_target;
      else if (j_take)
         nextPc = jTgt;
      else if (br_take)
         nextPc = brTgt;
   end

   // PC and redirect flag registers; redirect marks the cycle after any taken transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_VEC;
         redirect <= 1'b0;
      end else begin
         if (accept)
            pc <= nextPc;
         redirect <= anyTake;
      end
   end

`ifdef PC_SEQUENCER_RAS_EN
   localparam int             SPW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
   localparam logic [SPW:0]   CNT_ONE  = (SPW+1)'(1);
   localparam logic [SPW:0]   CNT_MAX  = (SPW+1)'(RAS_DEPTH);

   logic [XLEN-1:0] rasMem [RAS_DEPTH];
   logic [SPW-1:0]  rasSp;
   logic [SPW:0]    rasCnt;
   logic [SPW-1:0]  topIdx;
   logic [SPW-1:0]  wrIdx;
   logic            callOk;
   logic            retOk;
   logic            replaceTop;

   assign callOk     = call & accept;
   assign retOk      = ret & accept;
   assign topIdx     = rasSp - SP_ONE;
   assign ras_empty  = (rasCnt == '0);
   assign ras_full   = (rasCnt == CNT_MAX);
   assign replaceTop = callOk & retOk & ~ras_empty;
   // The write slot is the free slot above top; once full it is the oldest entry, giving circular overwrite.
   assign wrIdx      = replaceTop ? topIdx : rasSp;
   assign ras_top    = ras_empty ? '0 : rasMem[topIdx];

   // Stack pointer and occupancy; sp points at the next free slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rasSp  <= '0;
         rasCnt <= '0;
      end else if (replaceTop) begin
         rasSp  <= rasSp;
      end else if (callOk) begin
         rasSp <= rasSp + SP_ONE;
         if (!ras_full)
            rasCnt <= rasCnt + CNT_ONE;
      end else if (retOk && !ras_empty) begin
         rasSp  <= rasSp - SP_ONE;
         rasCnt <= rasCnt - CNT_ONE;
      end
   end

   // Entry storage is not reset; writes are blocked while rst is high so a reset drops the push.
   always_ff @(posedge clk) begin
      if (!rst && callOk)
         rasMem[wrIdx] <= pc_plus4;
   end
`else
   logic unusedRas;

   assign unusedRas = call ^ ret;
   assign ras_top   = '0;
   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        br_take;
   logic [15:0] br_offset;
   logic        j_take;
   logic [25:0] j_addr;
   logic        jr_take;
   logic [31:0] jr_target;
   logic        call;
   logic        ret;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic [31:0] ras_top;
   logic        ras_empty;
   logic        ras_full;

   int totalCnt = 0;
   int badCnt   = 0;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .stall(stall),
      .br_take(br_take), .br_offset(br_offset),
      .j_take(j_take), .j_addr(j_addr),
      .jr_take(jr_take), .jr_target(jr_target),
      .call(call), .ret(ret),
      .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect),
      .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full)
   );

   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      totalCnt++;
      if (got !== exp) begin
         badCnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn();
      stall = 0; br_take = 0; br_offset = '0; j_take = 0; j_addr = '0;
      jr_take = 0; jr_target = '0; call = 0; ret = 0;
   endtask

   task automatic jumpTo(input logic [31:0] tgt);
      jr_take = 1; jr_target = tgt;
      step();
      jr_take = 0;
   endtask

   initial begin
      logic [31:0] callTgt [5];
      logic [31:0] retTop [5];
      callTgt = '{32'h200, 32'h300, 32'h400, 32'h500, 32'h1000};
      retTop  = '{32'h404, 32'h304, 32'h204, 32'h0, 32'h0};

      clearIn();
      rst = 1;
      step();
      step();
      checkEq("rst_pc", pc, 32'h3000);
      checkEq("rst_redirect", redirect, 0);
      checkEq("rst_empty", ras_empty, 1);
      checkEq("rst_full", ras_full, 0);
      checkEq("rst_top", ras_top, 0);
      rst = 0;

      checkEq("rel_pc0", pc, 32'h3000);
      step();
      checkEq("rel_pc1", pc, 32'h3004);
      checkEq("rel_redir1", redirect, 0);
      step();
      checkEq("rel_pc2", pc, 32'h3008);
      checkEq("rel_redir2", redirect, 0);
      step();
      step();
      checkEq("pc_3010", pc, 32'h3010);

      br_take = 1; br_offset = 16'hFFFE;
      step();
      checkEq("br_pc", pc, 32'h300C);
      checkEq("br_redir", redirect, 1);
      br_take = 0;
      step();
      checkEq("br_after_pc", pc, 32'h3010);
      checkEq("br_after_redir", redirect, 0);

      jr_take = 1; j_take = 1; br_take = 1; stall = 1;
      jr_target = 32'h8000; j_addr = 26'h1234; br_offset = 16'h0010;
      step();
      checkEq("prio_pc", pc, 32'h8000);
      checkEq("prio_redir", redirect, 1);
      clearIn();

      jumpTo(32'h0040_0000);
      checkEq("jr_pc", pc, 32'h0040_0000);
      j_take = 1; j_addr = 26'h0000100;
      step();
      checkEq("j_pc", pc, 32'h400);
      checkEq("j_redir", redirect, 1);
      j_take = 0; stall = 1; call = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checkEq($sformatf("stall_pc%0d", i), pc, 32'h400);
         checkEq($sformatf("stall_redir%0d", i), redirect, 0);
         checkEq($sformatf("stall_empty%0d", i), ras_empty, 1);
      end
      clearIn();

      jumpTo(32'hFFFF_FFFC);
      step();
      checkEq("wrap_pc", pc, 32'h0);
      checkEq("wrap_redir", redirect, 0);

      jumpTo(32'h100);
      for (int i = 0; i < 5; i++) begin
         call = 1; jr_take = 1; jr_target = callTgt[i];
         step();
      end
      clearIn();
      checkEq("call_pc", pc, 32'h1000);
`ifdef PC_SEQUENCER_RAS_EN
      checkEq("call_full", ras_full, 1);
      checkEq("call_top", ras_top, 32'h504);
      ret = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         checkEq($sformatf("ret_top%0d", i), ras_top, retTop[i]);
         checkEq($sformatf("ret_empty%0d", i), ras_empty, (i >= 3) ? 1 : 0);
      end
      ret = 0;
      checkEq("ret_full", ras_full, 0);
      call = 1; ret = 1;
      step();
      checkEq("cr_push_top", ras_top, 32'h1018);
      checkEq("cr_push_empty", ras_empty, 0);
      step();
      checkEq("cr_repl_top", ras_top, 32'h101C);
      call = 0;
      step();
      checkEq("cr_pop_empty", ras_empty, 1);
`else
      checkEq("nomac_empty", ras_empty, 1);
      checkEq("nomac_full", ras_full, 0);
      checkEq("nomac_top", ras_top, 0);
`endif
      clearIn();

      call = 1;
      step();
      step();
      call = 0;
      #3;
      rst = 1;
      #1;
      checkEq("async_pc", pc, 32'h3000);
      checkEq("async_empty", ras_empty, 1);
      checkEq("async_redir", redirect, 0);
      step();
      rst = 0;
      step();
      checkEq("post_rst_pc", pc, 32'h3004);
      checkEq("post_rst_empty", ras_empty, 1);

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
